captura_jogada: RTL

//  Captures one chess move: four 3-bit board coordinates (origin col, origin row, dest col, dest row)

---
 rtl/captura_jogada.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/captura_jogada.sv
// -----------------------------------------------------------------------------
// captura_jogada
//
// Captures one chess move as four 3-bit board coordinates entered one at a
// time (origin column, origin row, destination column, destination row), then
// runs the column pair and the row pair through an external comparador_85.
// It publishes the move together with a direction summary per axis.
//
// Build option:
//   CAPTURA_TIMEOUT_EN  when defined, a partially entered move is abandoned
//                       after TIMEOUT_CYC consecutive idle cycles. In that
//                       case fase returns to 0 and timeout pulses for one
//                       cycle. When undefined, no idle counter exists and
//                       timeout is tied low.
//
// Parameters:
//   COORD_W      coordinate width (3, matches comparador_85 A/B)
//   TIMEOUT_CYC  idle cycles before an unfinished capture is abandoned
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   limpa                   synchronous abort back to the first coordinate
//   coord, coord_valid      coordinate value and its 1-cycle strobe
//   cmp_ALB/AGB/AEB         comparator results (comparador_85 outputs)
//   cmp_A, cmp_B            comparator operands (A = destination, B = origin)
//   cmp_ALBi/AGBi/AEBi      comparator cascade inputs (constant 0/0/1)
//   ready                   coordinates are being accepted
//   fase                    index of the next coordinate expected
//   pronto                  1-cycle pulse: result outputs just updated
//   origem, destino         {col,row} of origin and destination
//   dcol_sinal, drow_sinal  00 equal, 01 dest>orig, 10 dest<orig, 11 bad
//   nula                    move does not leave its square
//   erro                    comparator gave an inconsistent answer
//   timeout                 1-cycle pulse when a capture is abandoned
// -----------------------------------------------------------------------------
module captura_jogada #(
    parameter int COORD_W     = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 limpa,
    input  logic [COORD_W-1:0]   coord,
    input  logic                 coord_valid,
    input  logic                 cmp_ALB,
    input  logic                 cmp_AGB,
    input  logic                 cmp_AEB,
    output logic [COORD_W-1:0]   cmp_A,
    output logic [COORD_W-1:0]   cmp_B,
    output logic                 cmp_ALBi,
    output logic                 cmp_AGBi,
    output logic                 cmp_AEBi,
    output logic                 ready,
    output logic [1:0]           fase,
    output logic                 pronto,
    output logic [2*COORD_W-1:0] origem,
    output logic [2*COORD_W-1:0] destino,
    output logic [1:0]           dcol_sinal,
    output logic [1:0]           drow_sinal,
    output logic                 nula,
    output logic                 erro,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        S_CAP     = 2'd0,
        S_CMP_COL = 2'd1,
        S_CMP_ROW = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Slot order matches fase: 0 col_o, 1 row_o, 2 col_d, 3 row_d.
    localparam int SLOT_COL_O = 0;
    localparam int SLOT_ROW_O = 1;
    localparam int SLOT_COL_D = 2;
    localparam int SLOT_ROW_D = 3;

    // Flag index 0 holds the column comparison, index 1 the row comparison.
    localparam int AX_COL = 0;
    localparam int AX_ROW = 1;

    state_t                 state_reg;
    logic [1:0]             fase_reg;
    logic                   ready_reg;
    logic [COORD_W-1:0]     slot_reg [4];
    logic [COORD_W-1:0]     cmp_a_reg;
    logic [COORD_W-1:0]     cmp_b_reg;
    logic [2:0]             flags_reg [2];   // {ALB,AGB,AEB} per axis
    logic                   pronto_reg;
    logic [2*COORD_W-1:0]   origem_reg;
    logic [2*COORD_W-1:0]   destino_reg;
    logic [1:0]             dcol_reg;
    logic [1:0]             drow_reg;
    logic                   nula_reg;
    logic                   erro_reg;
    logic                   timeout_hit;

    logic [1:0]             sinal_w [2];
    logic [1:0]             incons_w;

    // Exactly one comparator flag must be set; anything else is reported
    // as 11 so a faulty or unconnected comparator never looks like a move.
    function automatic logic [1:0] sinal_of(input logic [2:0] f);
        logic [1:0] s;
        s = 2'b11;
        case (f)
            3'b010:  s = 2'b01;   // AGB: destination greater
            3'b100:  s = 2'b10;   // ALB: destination smaller
            3'b001:  s = 2'b00;   // AEB: equal
            default: s = 2'b11;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            assign sinal_w[gi]  = sinal_of(flags_reg[gi]);
            assign incons_w[gi] = (sinal_w[gi] == 2'b11);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Main FSM. All outputs are registered here; the operand registers are
    // loaded on the edge that enters each compare state, so cmp_A/cmp_B are
    // already stable for the whole cycle in which the comparator result is
    // sampled.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_CAP;
            fase_reg    <= 2'd0;
            ready_reg   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                slot_reg[i] <= '0;
            end
            cmp_a_reg   <= '0;
            cmp_b_reg   <= '0;
            flags_reg[AX_COL] <= 3'b000;
            flags_reg[AX_ROW] <= 3'b000;
            pronto_reg  <= 1'b0;
            origem_reg  <= '0;
            destino_reg <= '0;
            dcol_reg    <= 2'b00;
            drow_reg    <= 2'b00;
            nula_reg    <= 1'b0;
            erro_reg    <= 1'b0;
        end else begin
            pronto_reg <= 1'b0;
            if (limpa) begin
                // Abort: restart capture, published results stay as they were.
                state_reg <= S_CAP;
                fase_reg  <= 2'd0;
                ready_reg <= 1'b1;
                cmp_a_reg <= '0;
                cmp_b_reg <= '0;
            end else begin
                case (state_reg)
                    S_CAP: begin
                        if (coord_valid) begin
                            slot_reg[fase_reg] <= coord;
                            fase_reg           <= fase_reg + 2'd1;   // wraps to 0 after row_d
                            if (fase_reg == 2'd3) begin
                                state_reg <= S_CMP_COL;
                                ready_reg <= 1'b0;
                                cmp_a_reg <= slot_reg[SLOT_COL_D];
                                cmp_b_reg <= slot_reg[SLOT_COL_O];
                            end
                        end else if (timeout_hit) begin
                            fase_reg <= 2'd0;
                        end
                    end
                    S_CMP_COL: begin
                        flags_reg[AX_COL] <= {cmp_ALB, cmp_AGB, cmp_AEB};
                        cmp_a_reg <= slot_reg[SLOT_ROW_D];
                        cmp_b_reg <= slot_reg[SLOT_ROW_O];
                        state_reg <= S_CMP_ROW;
                    end
                    S_CMP_ROW: begin
                        flags_reg[AX_ROW] <= {cmp_ALB, cmp_AGB, cmp_AEB};
                        cmp_a_reg <= '0;
                        cmp_b_reg <= '0;
                        state_reg <= S_DONE;
                    end
                    S_DONE: begin
                        // Publish everything on one edge so consumers never
                        // see a half-updated move.
                        origem_reg  <= {slot_reg[SLOT_COL_O], slot_reg[SLOT_ROW_O]};
                        destino_reg <= {slot_reg[SLOT_COL_D], slot_reg[SLOT_ROW_D]};
                        dcol_reg    <= sinal_w[AX_COL];
                        drow_reg    <= sinal_w[AX_ROW];
                        nula_reg    <= (sinal_w[AX_COL] == 2'b00) && (sinal_w[AX_ROW] == 2'b00);
                        erro_reg    <= |incons_w;
                        pronto_reg  <= 1'b1;
                        ready_reg   <= 1'b1;
                        state_reg   <= S_CAP;
                    end
                    default: begin
                        state_reg <= S_CAP;
                        fase_reg  <= 2'd0;
                        ready_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef CAPTURA_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Idle watchdog: only armed while a move is partially entered. The count
    // holds the number of idle cycles already seen, so the abort fires on the
    // TIMEOUT_CYC-th consecutive idle cycle.
    // -------------------------------------------------------------------------
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] idle_cnt_reg;
    logic             timeout_reg;
    logic             armed;

    assign armed       = (state_reg == S_CAP) && (fase_reg != 2'd0) && !limpa;
    assign timeout_hit = armed && !coord_valid && (idle_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit;
            if (!armed || coord_valid || timeout_hit) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    // Capture waits indefinitely; the parameter stays referenced so both
    // builds accept the same parameter list.
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    assign cmp_A      = cmp_a_reg;
    assign cmp_B      = cmp_b_reg;
    assign cmp_ALBi   = 1'b0;
    assign cmp_AGBi   = 1'b0;
    assign cmp_AEBi   = 1'b1;
    assign ready      = ready_reg;
    assign fase       = fase_reg;
    assign pronto     = pronto_reg;
    assign origem     = origem_reg;
    assign destino    = destino_reg;
    assign dcol_sinal = dcol_reg;
    assign drow_sinal = drow_reg;
    assign nula       = nula_reg;
    assign erro       = erro_reg;

endmodule
